// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: controller
// state encoding, Booth digit encoding, default operand width and the
// window-to-digit decoder.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  // Map a 3-bit window {m[2i+1], m[2i], m[2i-1]} to its radix-4 digit.
  function automatic booth_digit_e booth_decode(input logic [2:0] window);
    case (window)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Issue/result handshake of the Booth sequential multiplier.
// master = issuing unit / result consumer, slave = booth_seq_ctrl.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);
  logic                 op_start;
  logic [WIDTH-1:0]     op_multiplicand;
  logic [WIDTH-1:0]     op_multiplier;
  logic                 op_busy;
  logic                 op_done;
  logic [2*WIDTH-1:0]   op_result;

  modport master (
    output op_start, op_multiplicand, op_multiplier,
    input  op_busy, op_done, op_result
  );

  modport slave (
    input  op_start, op_multiplicand, op_multiplier,
    output op_busy, op_done, op_result
  );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-4 Booth step: decodes a 3-bit multiplier window
// and adds 0, +-1 or +-2 times the sign-extended multiplicand, shifted by
// 2*idx, into the 2*WIDTH accumulator (modulo 2^(2*WIDTH)).
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = 5
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2:0]         window,
  input  logic [2*WIDTH-1:0] mcand_ext,
  input  logic [IDX_W-1:0]   idx,
  output logic [2*WIDTH-1:0] acc_next
);

  booth_digit_e       digit;
  logic [2*WIDTH-1:0] base;
  logic [2*WIDTH-1:0] term;

  // Select the partial product for this window and accumulate it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    term  = '0;
    digit = booth_decode(window);
    base  = mcand_ext << {idx, 1'b0};
    unique case (digit)
      ZERO:    term = '0;
      POS1:    term = base;
      POS2:    term = base << 1;
      NEG1:    term = -base;
      NEG2:    term = -(base << 1);
      default: term = '0;
    endcase
    acc_next = acc + term;
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller. Accepts a signed
// WIDTH x WIDTH pair on op_start, retires one Booth window per clock and
// reports the 2*WIDTH product with a one-cycle op_done pulse.
// Optional macro BOOTH_ZERO_SKIP_EN: finish early once all remaining
// multiplier windows decode to zero.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  booth_seq_ctrl_if.slave  bus
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH:0]     m_ext;
  logic [2:0]         window;
  logic               accept;
  logic               last_window;

  // A new pair is taken whenever the block is not mid-operation.
  assign accept = (state_q != RUN) && bus.op_start;

  // m[-1] = 0 is appended below bit 0 so window i starts at bit 2i.
  assign m_ext  = {mplier_q, 1'b0};
  assign window = m_ext[{idx_q, 1'b0} +: 3];

`ifdef BOOTH_ZERO_SKIP_EN
  logic [WIDTH-1:0] rest;
  logic             rest_uniform;

  // Bits m[WIDTH-1 : 2i+1] all equal means every later window is 000 or 111.
  always_comb begin
    rest         = WIDTH'($signed(mplier_q) >>> {idx_q, 1'b1});
    rest_uniform = (rest == '0) || (rest == '1);
    last_window  = (idx_q == IDX_W'(N - 1)) || rest_uniform;
  end
`else
  assign last_window = (idx_q == IDX_W'(N - 1));
`endif

  booth_step #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_step (
    .acc       (acc_q),
    .window    (window),
    .mcand_ext (mcand_q),
    .idx       (idx_q),
    .acc_next  (acc_next)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> (RUN on back-to-back start | IDLE).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.op_start) state_d = RUN;
      RUN:     if (last_window)  state_d = DONE;
      DONE:    state_d = bus.op_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.op_busy = (state_q == RUN);
    bus.op_done = (state_q == DONE);
  end

  assign bus.op_result = result_q;

  // Operand capture, per-window accumulation and result latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      mcand_q  <= {{WIDTH{bus.op_multiplicand[WIDTH-1]}}, bus.op_multiplicand};
      mplier_q <= bus.op_multiplier;
      acc_q    <= '0;
      idx_q    <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_next;
      idx_q <= idx_q + 1'b1;
      if (last_window) result_q <= acc_next;
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=64). Products come from
// signed 128-bit arithmetic; latency comes from the Booth digit string of
// the multiplier (fixed N, or last non-zero digit + 1 with
// BOOTH_ZERO_SKIP_EN).
module tb_booth_seq_ctrl;

  localparam int W = 64;
  localparam int N = W / 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  booth_seq_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_product(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic int model_latency(input logic [63:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    int          last;
    logic [64:0] ext;
    logic [2:0]  w;
    last = 0;
    ext  = {b, 1'b0};
    for (int i = 0; i < N; i++) begin
      w = ext[2*i +: 3];
      if (w != 3'b000 && w != 3'b111) last = i;
    end
    return last + 1;
`else
    return N;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair for one edge, then scramble the operand inputs.
  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    bus.op_start        = 1'b1;
    bus.op_multiplicand = a;
    bus.op_multiplier   = b;
    step();
    bus.op_start        = 1'b0;
    bus.op_multiplicand = ~a;
    bus.op_multiplier   = ~b;
  endtask

  task automatic wait_done(output int elapsed, output int busy_cnt, output logic seen);
    elapsed  = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (bus.op_done) begin
        seen = 1'b1;
        break;
      end
      elapsed++;
      if (bus.op_busy) busy_cnt++;
      step();
    end
  endtask

  task automatic finish_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    int   elapsed, busy_cnt;
    logic seen;
    wait_done(elapsed, busy_cnt, seen);
    check({tag, "_done"}, 128'(seen), 128'd1);
    check({tag, "_lat"}, 128'(elapsed), 128'(model_latency(b)));
    check({tag, "_busy"}, 128'(busy_cnt), 128'(model_latency(b)));
    check({tag, "_res"}, bus.op_result, model_product(a, b));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    issue(a, b);
    finish_op(tag, a, b);
    step();
    check({tag, "_pulse"}, 128'(bus.op_done), 128'd0);
  endtask

  initial begin
    int          elapsed, busy_cnt;
    logic        seen;
    logic [63:0] a, b, a2, b2;

    bus.op_start        = 1'b0;
    bus.op_multiplicand = '0;
    bus.op_multiplier   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(bus.op_busy), 128'd0);
    check("rst_done", 128'(bus.op_done), 128'd0);
    check("rst_res", bus.op_result, 128'd0);
    reset_n = 1'b1;
    step();

    // Directed pairs
    run_op("p3x5", 64'd3, 64'd5);
    run_op("p7xm2", 64'd7, -64'sd2);
    run_op("pminxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run_op("pm1xm1", '1, '1);
    run_op("pbig", 64'h0123_4567_89AB_CDEF, 64'h4000_0000_0000_0000);
    run_op("pmax", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);

    // Back-to-back issue: new start held during the DONE cycle
    a  = 64'h0000_FFFF_0000_ABCD;
    b  = 64'h1234_5678_9101_ABCD;
    a2 = 64'hFEDC_BA98_7654_3210;
    b2 = 64'h8765_4321_0FED_CBA9;
    issue(a, b);
    finish_op("b2b_first", a, b);
    issue(a2, b2);
    check("b2b_no_idle", 128'(bus.op_busy), 128'd1);
    finish_op("b2b_second", a2, b2);
    step();

    // op_start during RUN is ignored
    a = 64'hDEAD_BEEF_0BAD_F00D;
    b = 64'h7123_4567_89AB_CDEF;
    issue(a, b);
    repeat (9) step();
    bus.op_start        = 1'b1;
    bus.op_multiplicand = 64'd11;
    bus.op_multiplier   = 64'd13;
    step();
    bus.op_start = 1'b0;
    check("ign_busy", 128'(bus.op_busy), 128'd1);
    wait_done(elapsed, busy_cnt, seen);
    check("ign_done", 128'(seen), 128'd1);
    check("ign_lat", 128'(elapsed + 10), 128'(model_latency(b)));
    check("ign_res", bus.op_result, model_product(a, b));
    step();

    // Reset in the middle of RUN
    issue(64'h1111_2222_3333_4444, 64'h7123_4567_89AB_CDEF);
    repeat (14) step();
    check("mid_busy_pre", 128'(bus.op_busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", 128'(bus.op_busy), 128'd0);
    check("mid_done", 128'(bus.op_done), 128'd0);
    check("mid_res", bus.op_result, 128'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen = seen | bus.op_done;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      seen = seen | bus.op_done | bus.op_busy;
    end
    check("mid_no_done", 128'(seen), 128'd0);

    // Randomized pairs
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(0, 255));
        2:       b = -64'($urandom_range(0, 4095));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
